// File: rtl/vga_pixel_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_pixel_sink                                                |
// | Brief    : 160x120x3 frame store fed by a plot stream, with clipping,    |
// |            clear engine, pixel counters and raster readback port.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module vga_pixel_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        start_clear,
    input  logic [2:0]  bg_colour,
    output logic        clear_busy,
    output logic        clear_done,
    input  logic        start_scan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_x,
    output logic [6:0]  out_y,
    output logic [2:0]  out_colour,
    output logic        out_last,
    output logic [14:0] pix_count,
    output logic [7:0]  clip_count
);
    localparam int          DEPTH       = WIDTH * HEIGHT;
    localparam logic [14:0] C_LAST_ADDR = 15'(DEPTH - 1);
    localparam logic [7:0]  C_WIDTH     = 8'(WIDTH);
    localparam logic [6:0]  C_HEIGHT    = 7'(HEIGHT);
    localparam logic [7:0]  C_X_MAX     = 8'(WIDTH - 1);
    localparam logic [6:0]  C_Y_MAX     = 7'(HEIGHT - 1);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_CLEAR = 1'b1} wr_state_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_VALID = 2'd2} sc_state_t;

    // y*160 + x without a multiplier (160 = 128 + 32).
    function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
        return {1'b0, py, 7'b0} + {3'b0, py, 5'b0} + {7'b0, px};
    endfunction

    wr_state_t   r_wstate, w_wstate_nxt;
    sc_state_t   r_sstate, w_sstate_nxt;
    logic [14:0] r_clr_addr;
    logic [2:0]  r_bg;
    logic [7:0]  r_scan_x;
    logic [6:0]  r_scan_y;
    logic [2:0]  r_rdata;
    logic [2:0]  r_mem [DEPTH];

    logic        w_on_screen;
    logic        w_we;
    logic [14:0] w_waddr;
    logic [2:0]  w_wdata;
    logic        w_plot_ok;
    logic        w_plot_clip;
    logic        w_clr_start;
    logic        w_pos_zero;
    logic        w_advance;
    logic        w_at_last;
    logic [14:0] w_raddr;

    assign w_on_screen = (x < C_WIDTH) && (y < C_HEIGHT);
    assign w_at_last   = (r_scan_x == C_X_MAX) && (r_scan_y == C_Y_MAX);
    assign w_raddr     = pix_addr(r_scan_x, r_scan_y);

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate   <= W_IDLE;
            r_clr_addr <= '0;
            r_bg       <= '0;
            pix_count  <= '0;
            clip_count <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_clr_start) begin
                r_bg       <= bg_colour;
                r_clr_addr <= '0;
                pix_count  <= '0;
                clip_count <= '0;
            end else begin
                if (clear_busy) begin
                    r_clr_addr <= r_clr_addr + 15'd1;
                end
                if (w_plot_ok && (pix_count != 15'h7FFF)) begin
                    pix_count <= pix_count + 15'd1;
                end
                if (w_plot_clip && (clip_count != 8'hFF)) begin
                    clip_count <= clip_count + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_we         = 1'b0;
        w_waddr      = r_clr_addr;
        w_wdata      = r_bg;
        w_plot_ok    = 1'b0;
        w_plot_clip  = 1'b0;
        w_clr_start  = 1'b0;
        clear_busy   = 1'b0;
        clear_done   = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (plot) begin
                    if (w_on_screen) begin
                        w_we      = 1'b1;
                        w_waddr   = pix_addr(x, y);
                        w_wdata   = colour;
                        w_plot_ok = 1'b1;
                    end else begin
                        w_plot_clip = 1'b1;
                    end
                end
                if (start_clear) begin
                    w_clr_start  = 1'b1;
                    w_wstate_nxt = W_CLEAR;
                end
            end
            W_CLEAR: begin
                clear_busy = 1'b1;
                w_we       = 1'b1;
                if (r_clr_addr == C_LAST_ADDR) begin
                    clear_done   = 1'b1;
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Frame store: no reset so it maps onto block RAM; read returns old data on collision.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        r_rdata <= r_mem[w_raddr];
    end

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sstate <= S_IDLE;
            r_scan_x <= '0;
            r_scan_y <= '0;
        end else begin
            r_sstate <= w_sstate_nxt;
            if (w_pos_zero || (w_advance && w_at_last)) begin
                r_scan_x <= '0;
                r_scan_y <= '0;
            end else if (w_advance) begin
                if (r_scan_x == C_X_MAX) begin
                    r_scan_x <= '0;
                    r_scan_y <= r_scan_y + 7'd1;
                end else begin
                    r_scan_x <= r_scan_x + 8'd1;
                end
            end
        end
    end

    always_comb begin
        w_sstate_nxt = r_sstate;
        w_pos_zero   = 1'b0;
        w_advance    = 1'b0;
        out_valid    = 1'b0;
        case (r_sstate)
            S_IDLE: begin
                if (start_scan) begin
                    w_pos_zero   = 1'b1;
                    w_sstate_nxt = S_FETCH;
                end
            end
            S_FETCH: w_sstate_nxt = S_VALID;
            S_VALID: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_advance    = 1'b1;
                    w_sstate_nxt = w_at_last ? S_IDLE : S_FETCH;
                end
            end
            default: w_sstate_nxt = S_IDLE;
        endcase
    end

    assign out_x      = r_scan_x;
    assign out_y      = r_scan_y;
    assign out_colour = out_valid ? r_rdata : 3'b000;
    assign out_last   = out_valid && w_at_last;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_pixel_sink                                             |
// | Brief    : Self-checking bench for vga_pixel_sink against a frame model. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_vga_pixel_sink;
    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        plot = 1'b0;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic [2:0]  colour = '0;
    logic        start_clear = 1'b0;
    logic [2:0]  bg_colour = '0;
    logic        start_scan = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_busy, clear_done, out_valid, out_last;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_colour;
    logic [14:0] pix_count;
    logic [7:0]  clip_count;

    vga_pixel_sink #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .plot(plot), .x(x), .y(y), .colour(colour),
        .start_clear(start_clear), .bg_colour(bg_colour),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .start_scan(start_scan), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .out_last(out_last),
        .pix_count(pix_count), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int model_mem [NPIX];
    int scanned [NPIX];
    int model_pix = 0;
    int model_clip = 0;

    typedef struct {
        int px;
        int py;
        int pc;
        bit clipped;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_plot(input int px, input int py, input int pc);
        if (px < W && py < H) begin
            model_mem[py * W + px] = pc;
            if (model_pix < 32767) model_pix++;
        end else if (model_clip < 255) begin
            model_clip++;
        end
    endfunction

    function automatic void model_fill(input int c);
        for (int i = 0; i < NPIX; i++) model_mem[i] = c;
        model_pix  = 0;
        model_clip = 0;
    endfunction

    // One plot strobe issued from a falling edge; counters are checked one edge later.
    task automatic do_plot(input int px, input int py, input int pc);
        plot   = 1'b1;
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(pc);
        @(negedge clk);
        plot = 1'b0;
        model_plot(px, py, pc);
        check("plot_pix_count", pix_count, model_pix);
        check("plot_clip_count", clip_count, model_clip);
    endtask

    task automatic run_scan(input int npix, input int stall_idx, input int clr_idx,
                            input int rescan_idx);
        int t0;
        int wait_n;
        out_ready  = 1'b1;
        start_scan = 1'b1;
        t0         = cyc;
        @(negedge clk);
        start_scan = 1'b0;
        check("scan_lat_fetch_valid", out_valid, 0);
        @(negedge clk);
        check("scan_lat_first_valid", out_valid, 1);
        for (int idx = 0; idx < npix; idx++) begin
            wait_n = 0;
            while (!out_valid && wait_n < 8) begin
                @(negedge clk);
                wait_n++;
            end
            if (!out_valid) begin
                checks++;
                errors++;
                $display("FAIL scan_timeout: no out_valid for pixel %0d, expected within 8 cycles", idx);
                return;
            end
            check("scan_x", out_x, idx % W);
            check("scan_y", out_y, idx / W);
            check("scan_colour", out_colour, model_mem[idx]);
            check("scan_last", out_last, (idx == NPIX - 1) ? 1 : 0);
            scanned[idx] = out_colour;
            if (idx == NPIX - 1)
                check("scan_frame_cycles", cyc - t0, 2 * NPIX + ((stall_idx >= 0) ? 5 : 0));
            if (idx == stall_idx) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_valid", out_valid, 1);
                    check("bp_x", out_x, idx % W);
                    check("bp_y", out_y, idx / W);
                    check("bp_colour", out_colour, model_mem[idx]);
                end
                out_ready = 1'b1;
            end
            start_clear = (idx == clr_idx);
            bg_colour   = 3'd0;
            start_scan  = (idx == rescan_idx);
            @(negedge clk);
            start_clear = 1'b0;
            start_scan  = 1'b0;
            check("scan_fetch_gap", out_valid, 0);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs [7];
        int   nbusy, ndone, done_at, exp_pix, exp_clip, strobes, base, a, b, d, px, py, pc;

        vecs[0] = '{px: 160, py: 0,   pc: 1, clipped: 1'b1};
        vecs[1] = '{px: 0,   py: 120, pc: 2, clipped: 1'b1};
        vecs[2] = '{px: 255, py: 127, pc: 3, clipped: 1'b1};
        vecs[3] = '{px: 0,   py: 0,   pc: 4, clipped: 1'b0};
        vecs[4] = '{px: 159, py: 0,   pc: 5, clipped: 1'b0};
        vecs[5] = '{px: 0,   py: 119, pc: 6, clipped: 1'b0};
        vecs[6] = '{px: 159, py: 119, pc: 7, clipped: 1'b0};

        // ---- reset ----
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clear_busy", clear_busy, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_colour", out_colour, 0);
        check("rst_pix_count", pix_count, 0);
        check("rst_clip_count", clip_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_plot(1, 1, 1);
        do_plot(200, 5, 1);

        // ---- clear with a same-cycle plot, then plots and a restart while busy ----
        start_clear = 1'b1;
        bg_colour   = 3'd0;
        plot = 1'b1; x = 8'd10; y = 7'd10; colour = 3'd6;
        @(negedge clk);
        start_clear = 1'b0;
        plot        = 1'b0;
        bg_colour   = 3'd7;
        model_fill(0);
        check("clear_busy_rise", clear_busy, 1);
        check("clear_zero_pix", pix_count, 0);
        check("clear_zero_clip", clip_count, 0);
        nbusy = 0; ndone = 0; done_at = 0;
        while (clear_busy && nbusy < 20000) begin
            nbusy++;
            if (clear_done) begin
                ndone++;
                done_at = nbusy;
            end
            plot        = (nbusy == 100 || nbusy == 101);
            x = 8'd10; y = 7'd10; colour = 3'd5;
            start_clear = (nbusy == 200);
            bg_colour   = 3'd5;
            @(negedge clk);
        end
        plot = 1'b0; start_clear = 1'b0;
        check("clear_busy_cycles", nbusy, NPIX);
        check("clear_done_pulses", ndone, 1);
        check("clear_done_at_last", done_at, NPIX);
        check("clear_done_low_after", clear_done, 0);
        check("clear_plot_pix", pix_count, 0);
        check("clear_plot_clip", clip_count, 0);

        // ---- randomized plots ----
        repeat (150) begin
            px = int'($urandom_range(0, 199));
            py = int'($urandom_range(20, 127));
            pc = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) do_plot(px, py, pc);
            else @(negedge clk);
        end

        // ---- radius-40 circle about (80,60), colour 2 ----
        base = model_pix; strobes = 0;
        a = 40; b = 0; d = 1 - 40;
        while (b <= a) begin
            do_plot(80 + a, 60 + b, 2); do_plot(80 - a, 60 + b, 2);
            do_plot(80 + a, 60 - b, 2); do_plot(80 - a, 60 - b, 2);
            do_plot(80 + b, 60 + a, 2); do_plot(80 - b, 60 + a, 2);
            do_plot(80 + b, 60 - a, 2); do_plot(80 - b, 60 - a, 2);
            strobes += 8;
            b++;
            if (d < 0) d += 2 * b + 1;
            else begin
                a--;
                d += 2 * (b - a) + 1;
            end
        end
        check("circle_strobes", int'(pix_count) - base, strobes);

        // ---- table: clipping and corner writes ----
        exp_pix  = pix_count;
        exp_clip = clip_count;
        for (int i = 0; i < 7; i++) begin
            do_plot(vecs[i].px, vecs[i].py, vecs[i].pc);
            if (vecs[i].clipped) exp_clip++;
            else exp_pix++;
            check("vec_pix_count", pix_count, exp_pix);
            check("vec_clip_count", clip_count, exp_clip);
        end

        // ---- full scan with backpressure, ignored restart, overlapping clear ----
        run_scan(NPIX, 3, 9700, 50);
        check("circle_east", scanned[60 * W + 120], 2);
        check("circle_west", scanned[60 * W + 40], 2);
        check("circle_north", scanned[20 * W + 80], 2);
        check("circle_south", scanned[100 * W + 80], 2);
        check("circle_centre_bg", scanned[60 * W + 80], 0);
        check("clear_plot_overwritten", scanned[10 * W + 10], 0);
        check("last_pixel_colour", scanned[NPIX - 1], 7);
        check("first_pixel_colour", scanned[0], 4);

        nbusy = 0;
        while (clear_busy && nbusy < 20000) begin
            @(negedge clk);
            nbusy++;
        end
        check("clear2_finished", clear_busy, 0);
        model_fill(0);
        check("clear2_pix", pix_count, 0);
        check("clear2_clip", clip_count, 0);

        // ---- single write, clip saturation, partial scan ----
        do_plot(80, 60, 2);
        check("single_pix_count", pix_count, 1);
        repeat (260) do_plot(200, 5, 3);
        check("clip_saturated", clip_count, 255);
        check("clip_sat_pix", pix_count, 1);
        run_scan(9682, -1, -1, -1);
        check("single_pixel_9680", scanned[9680], 2);
        check("single_pixel_9679", scanned[9679], 0);

        // ---- asynchronous reset during a clear and a scan ----
        start_clear = 1'b1;
        bg_colour   = 3'd1;
        @(negedge clk);
        start_clear = 1'b0;
        check("abort_busy_pre", clear_busy, 1);
        check("abort_scan_x_pre", out_x, 9682 % W);
        #2 rst_n = 1'b0;
        #1;
        check("abort_clear_busy", clear_busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_x", out_x, 0);
        check("abort_out_y", out_y, 0);
        check("abort_out_colour", out_colour, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_busy_stays_low", clear_busy, 0);
        check("abort_valid_stays_low", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_pixel_sink.md
# vga_pixel_sink

Consumer end of the plot stream that the shape-drawing FSMs (circle, line, fill) produce. It accepts (x, y, colour, plot) writes into a 160×120×3-bit frame store and clips off-screen coordinates. It counts accepted and clipped pixels, and streams the stored frame back in raster order over a valid/ready port. It is the sink that simulation benches and on-chip self-checks use to inspect what a drawing engine actually rendered.

## Interface
- `WIDTH`, 160: visible columns.
- `HEIGHT`, 120: visible rows.
- `clk`  in  1  system clock (CLOCK_50 domain); the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `plot`  in  1  write strobe; one pixel per cycle where high.
- `x`  in  8  column of the write.
- `y`  in  7  row of the write.
- `colour`  in  3  pixel colour.
- `start_clear`  in  1  pulse; fill the frame with `bg_colour`.
- `bg_colour`  in  3  fill colour, sampled on `start_clear`.
- `clear_busy`  out  1  high while clearing.
- `clear_done`  out  1  one-cycle pulse on the last clear write.
- `start_scan`  in  1  pulse; begin raster readback.
- `out_valid`  out  1  readback pixel valid.
- `out_ready`  in  1  downstream accepts the pixel.
- `out_x`  out  8  readback column.
- `out_y`  out  7  readback row.
- `out_colour`  out  3  readback colour.
- `out_last`  out  1  high with pixel (159,119).
- `pix_count`  out  15  accepted writes, saturating at 32767.
- `clip_count`  out  8  clipped writes, saturating at 255.

## Operation
**Frame store**
- Dual-port, 19200×3: one write port, one synchronous-read port.
- Address = y·160 + x, computed as (y<<7)+(y<<5)+x in 15 bits.
- Contents are not reset. A clear is required before contents are meaningful.

**Write FSM (W_IDLE, W_CLEAR)**
- In W_IDLE, `plot` with x<160 and y<120 writes the pixel and increments `pix_count`.
- In W_IDLE, `plot` with x≥160 or y≥120 writes nothing and increments `clip_count`.
- In W_IDLE, `start_clear` has these effects:
  - Latches `bg_colour`.
  - Zeroes both counters on the next edge.
  - Enters W_CLEAR.
  - A `plot` in the same cycle is still processed, then overwritten by the clear.
- In W_CLEAR, the block writes the latched colour to address 0..19199, one per cycle.
- In W_CLEAR, `plot` is dropped and counts nothing; `start_clear` is ignored.
- `clear_done` pulses on the cycle that writes address 19199. The next state is W_IDLE.

**Scan FSM (S_IDLE, S_FETCH, S_VALID)**
- `start_scan` in S_IDLE sets the scan position to (0,0) and moves to S_FETCH. In any other state it is ignored.
- S_FETCH presents the read address for one cycle, then moves to S_VALID.
- S_VALID asserts `out_valid`, with `out_colour` driven from the memory read data.
  - Read address is held, so all outputs stay stable while `out_ready` is low.
- Handshake `out_valid && out_ready`:
  - Advances x. At 159, x wraps to 0 and y increments.
  - Moves to S_FETCH.
  - On (159,119), moves to S_IDLE instead.
- Scan runs concurrently with writes and clears, and is independent of the write FSM.
- Same-address read and write in one cycle: the read returns old data.

## Timing
- **Reset values (asynchronous):**
  - Both FSMs in IDLE.
  - `clear_busy`=0, `clear_done`=0, `out_valid`=0, `out_last`=0.
  - `out_x`=0, `out_y`=0, `out_colour`=0.
  - `pix_count`=0, `clip_count`=0.
- Reset mid-operation aborts any clear or scan immediately. Partially written memory is left as-is.
- **Write path:**
  - A write is visible to a read issued on the next cycle or later.
  - Counters update on the edge after the `plot` cycle.
- **Clear timing:**
  - `clear_busy` rises the cycle after `start_clear` and stays high for 19200 cycles.
  - `clear_done` coincides with the final busy cycle.
- **Scan timing:**
  - `start_scan` at cycle 0 gives the first `out_valid` at cycle 2.
  - With `out_ready` held high, throughput is one pixel per 2 cycles; a full frame takes 38400 cycles after start.
  - `out_last` is asserted only while `out_valid` is high for (159,119).

## Test plan
- **Reset and clear:**
  - Stimulus: hold `rst_n` low for 3 cycles, then pulse `start_clear` with `bg_colour`=0.
  - Required: `clear_busy` high for exactly 19200 cycles, a single `clear_done`, and `pix_count`=0.
- **Single write:**
  - Stimulus: plot (80,60) with colour 3'b010, then scan with `out_ready`=1.
  - Required: readback pixel index 9680 has colour 2; all others are 0; `pix_count`=1.
- **Clipping:**
  - Stimulus: plots at (160,0), (0,120) and (255,127), then (159,119) with colour 7.
  - Required: `clip_count`=3, `pix_count`=1, and the last scanned pixel has colour 7 with `out_last`=1.
- **Backpressure:**
  - Stimulus: during a scan, drop `out_ready` for 5 cycles at pixel (3,0).
  - Required: `out_valid`, `out_x`=3, `out_y`=0 and `out_colour` all hold unchanged; scan resumes with no pixel skipped or duplicated.
- **Plot during clear:**
  - Stimulus: plot (10,10) colour 5 while `clear_busy` is high.
  - Required: pixel remains `bg_colour` and neither counter changes. A `start_clear` with a same-cycle plot yields `bg_colour` at that pixel.
- **Radius-40 green circle:**
  - Stimulus: feed the circle points for centre (80,60), radius 40, then scan.
  - Required:
    - (120,60), (40,60), (80,20) and (80,100) read colour 2.
    - (80,60) reads the background colour.
    - `pix_count` equals the number of plot strobes.
